// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the 8255 PPI access scheduler
//
// Purpose: scheduler state encoding, 8255 register addresses, control-word
// bit positions, the default init control word and a counter-load helper.
package ppi_pkg;

  typedef enum logic [3:0] {
    ST_INIT_RST,
    ST_INIT_SETUP,
    ST_INIT_STROBE,
    ST_INIT_HOLD,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } ppi_state_t;

  localparam logic [1:0] A_PORTA = 2'b00;
  localparam logic [1:0] A_PORTB = 2'b01;
  localparam logic [1:0] A_PORTC = 2'b10;
  localparam logic [1:0] A_CWR   = 2'b11;

  // Control-word bit positions (mode-set word)
  localparam int CW_MODE_FLAG = 7;
  localparam int CW_PA_DIR    = 4;
  localparam int CW_PCU_DIR   = 3;
  localparam int CW_PB_DIR    = 1;
  localparam int CW_PCL_DIR   = 0;

  // Mode-set flag only: mode 0, every port an output
  localparam logic [7:0] INIT_CWR_DEFAULT = 8'h80;

  // Timed states count down to zero, so a state lasting n cycles loads n-1
  function automatic logic [3:0] cyc_load(input int unsigned n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/ppi_rr_arbiter.sv
// rtl/ppi_rr_arbiter.sv - two-way round-robin arbiter
//
// Purpose: picks one of two requesters; on a tie the one not granted last wins.
// Ports:
//   i_req      request vector
//   i_en       grant enable (grants are suppressed when low)
//   i_last     index of the requester granted last
//   o_grant    one-hot grant
//   o_last_nx  updated last-granted index
module ppi_rr_arbiter (
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_last_nx
);

  always_comb begin
    o_grant   = 2'b00;
    o_last_nx = i_last;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
    if (o_grant != 2'b00) o_last_nx = o_grant[1];
  end

endmodule

// File: rtl/ppi_access_scheduler.sv
// rtl/ppi_access_scheduler.sv - sequences and arbitrates bus cycles to an 8255 PPI
//
// Purpose: pulses PPI reset, writes the init control word, then serves two
// requesters round-robin with timed CS/RD/WR/A/D cycles.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_req, i_req_wr, i_req_a,
//   i_req_wdata                        per-requester request and operands
//   o_ack, o_rdata, o_ready            completion pulse, read data, init done
//   o_ppi_reset, o_cs, o_rd, o_wr,
//   o_a, o_d_out, o_d_oe, i_d_in       8255 processor-side bus
module ppi_access_scheduler
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RST_CYC    = 4,
  parameter logic [7:0]  INIT_CWR   = INIT_CWR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_req_wr,
  input  logic [3:0]  i_req_a,
  input  logic [15:0] i_req_wdata,
  output logic [1:0]  o_ack,
  output logic [7:0]  o_rdata,
  output logic        o_ready,
  output logic        o_ppi_reset,
  output logic        o_cs,
  output logic        o_rd,
  output logic        o_wr,
  output logic [1:0]  o_a,
  output logic [7:0]  o_d_out,
  output logic        o_d_oe,
  input  logic [7:0]  i_d_in
);

  localparam logic [3:0] L_SETUP  = cyc_load(SETUP_CYC);
  localparam logic [3:0] L_STROBE = cyc_load(STROBE_CYC);
  localparam logic [3:0] L_HOLD   = cyc_load(HOLD_CYC);
  localparam logic [3:0] L_RST    = cyc_load(RST_CYC);

  ppi_state_t r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic       r_last, w_last_nx;
  logic [1:0] r_gnt, w_grant;
  logic       w_grant_en, w_load_init;
  logic       w_bus_nx, w_strobe_nx;

  // Operation being carried out: either the init write or a latched request
  logic       r_op_wr, w_op_wr_nx;
  logic [1:0] r_op_a, w_op_a_nx;
  logic [7:0] r_op_d, w_op_d_nx;

  logic       r_ppi_reset, r_cs, r_rd, r_wr, r_d_oe, r_ready;
  logic [1:0] r_a, r_ack;
  logic [7:0] r_d_out, r_rdata;

  assign w_grant_en = (r_state == ST_IDLE);

  ppi_rr_arbiter u_arb (
    .i_req     (i_req),
    .i_en      (w_grant_en),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_last_nx (w_last_nx)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_load_init = 1'b0;
    case (r_state)
      ST_INIT_RST: begin
        if (r_cnt == 4'd0) begin
          w_state_nx  = ST_INIT_SETUP;
          w_cnt_nx    = L_SETUP;
          w_load_init = 1'b1;
        end else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_INIT_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = ST_INIT_STROBE;
          w_cnt_nx   = L_STROBE;
        end else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_INIT_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = ST_INIT_HOLD;
          w_cnt_nx   = L_HOLD;
        end else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_INIT_HOLD: begin
        if (r_cnt == 4'd0) w_state_nx = ST_IDLE;
        else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          w_state_nx = ST_SETUP;
          w_cnt_nx   = L_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = ST_STROBE;
          w_cnt_nx   = L_STROBE;
        end else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = L_HOLD;
        end else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) w_state_nx = ST_DONE;
        else w_cnt_nx = r_cnt - 4'd1;
      end
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_INIT_RST;
    endcase
  end

  // Operands are captured only at the grant edge, so later REQ_* changes are ignored
  always_comb begin
    w_op_wr_nx = r_op_wr;
    w_op_a_nx  = r_op_a;
    w_op_d_nx  = r_op_d;
    if (w_load_init) begin
      w_op_wr_nx = 1'b1;
      w_op_a_nx  = A_CWR;
      w_op_d_nx  = INIT_CWR;
    end else if (w_grant != 2'b00) begin
      w_op_wr_nx = w_grant[1] ? i_req_wr[1]        : i_req_wr[0];
      w_op_a_nx  = w_grant[1] ? i_req_a[3:2]       : i_req_a[1:0];
      w_op_d_nx  = w_grant[1] ? i_req_wdata[15:8]  : i_req_wdata[7:0];
    end
  end

  // Bus outputs are decoded from the next state so they leave a flop directly
  always_comb begin
    w_bus_nx    = 1'b0;
    w_strobe_nx = 1'b0;
    case (w_state_nx)
      ST_INIT_SETUP, ST_INIT_HOLD, ST_SETUP, ST_HOLD: w_bus_nx = 1'b1;
      ST_INIT_STROBE, ST_STROBE: begin
        w_bus_nx    = 1'b1;
        w_strobe_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_INIT_RST;
      r_cnt       <= L_RST;
      r_last      <= 1'b1;
      r_gnt       <= 2'b00;
      r_op_wr     <= 1'b0;
      r_op_a      <= 2'b00;
      r_op_d      <= 8'h00;
      r_ppi_reset <= 1'b1;
      r_cs        <= 1'b1;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_a         <= 2'b00;
      r_d_out     <= 8'h00;
      r_d_oe      <= 1'b0;
      r_ack       <= 2'b00;
      r_rdata     <= 8'h00;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_last      <= w_last_nx;
      if (w_grant != 2'b00) r_gnt <= w_grant;
      r_op_wr     <= w_op_wr_nx;
      r_op_a      <= w_op_a_nx;
      r_op_d      <= w_op_d_nx;
      r_ppi_reset <= (w_state_nx == ST_INIT_RST);
      r_cs        <= !w_bus_nx;
      r_wr        <= !(w_strobe_nx && w_op_wr_nx);
      r_rd        <= !(w_strobe_nx && !w_op_wr_nx);
      r_a         <= w_bus_nx ? w_op_a_nx : 2'b00;
      r_d_oe      <= w_bus_nx && w_op_wr_nx;
      r_d_out     <= (w_bus_nx && w_op_wr_nx) ? w_op_d_nx : 8'h00;
      r_ack       <= (w_state_nx == ST_DONE) ? r_gnt : 2'b00;
      r_ready     <= r_ready || (w_state_nx == ST_IDLE);
      // Capture on the edge that ends the last strobe cycle of a read
      if (r_state == ST_STROBE && r_cnt == 4'd0 && !r_op_wr) r_rdata <= i_d_in;
    end
  end

  assign o_ppi_reset = r_ppi_reset;
  assign o_cs        = r_cs;
  assign o_rd        = r_rd;
  assign o_wr        = r_wr;
  assign o_a         = r_a;
  assign o_d_out     = r_d_out;
  assign o_d_oe      = r_d_oe;
  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_ready     = r_ready;

endmodule

// File: tb/tb_ppi_access_scheduler.sv
// tb/tb_ppi_access_scheduler.sv - directed scoreboard bench for ppi_access_scheduler
module tb_ppi_access_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [3:0]  req_a;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        ready;
  logic        ppi_reset;
  logic        cs, rd_n, wr_n;
  logic [1:0]  a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;

  always #5 clk = ~clk;

  ppi_access_scheduler dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_wr    (req_wr),
    .i_req_a     (req_a),
    .i_req_wdata (req_wdata),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_ready     (ready),
    .o_ppi_reset (ppi_reset),
    .o_cs        (cs),
    .o_rd        (rd_n),
    .o_wr        (wr_n),
    .o_a         (a),
    .o_d_out     (d_out),
    .o_d_oe      (d_oe),
    .i_d_in      (d_in)
  );

  typedef struct {
    logic [1:0] ack;
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] din;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] eack, input logic ewr, input logic [1:0] ea,
                      input logic [7:0] ed, input logic [7:0] edin);
    exp_t e;
    e.ack = eack; e.wr = ewr; e.a = ea; e.d = ed; e.din = edin;
    sb.push_back(e);
  endtask

  task automatic start_req(input int idx, input logic wr, input logic [1:0] ra,
                           input logic [7:0] wd, input logic [7:0] din);
    req_wr[idx]          = wr;
    req_a[idx*2 +: 2]    = ra;
    req_wdata[idx*8 +: 8] = wd;
    req[idx]             = 1'b1;
    push((idx == 1) ? 2'b10 : 2'b01, wr, ra, wd, din);
  endtask

  // Follows one bus cycle from the current negedge sample through its ACK cycle
  task automatic watch_access(input int exp_wait, input bit keep);
    exp_t e;
    int w;
    int k;
    logic [15:0] wm;
    logic [15:0] rm;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb[0];
    w = 0;
    while (cs !== 1'b0 && w < 30) begin
      chk("strobe_while_cs_high", {rd_n, wr_n}, 2'b11);
      chk("ack_while_idle", ack, 0);
      @(negedge clk);
      w++;
    end
    chk("cs_timeout", w < 30, 1);
    if (exp_wait >= 0) chk("req_latency", w, exp_wait);
    k = 0; wm = '0; rm = '0;
    while (cs === 1'b0 && k < 16) begin
      chk("addr", a, e.a);
      chk("d_oe", d_oe, e.wr);
      if (e.wr) chk("d_out", d_out, e.d);
      chk("ack_busy", ack, 0);
      chk("ready_busy", ready, e.ack != 0);
      chk("ppi_reset_busy", ppi_reset, 0);
      wm[k] = ~wr_n;
      rm[k] = ~rd_n;
      d_in = (rd_n === 1'b0) ? e.din : 8'hFF;
      if (!keep && e.ack != 0 && k == 1) begin
        req_a = ~req_a; req_wdata = ~req_wdata; req_wr = ~req_wr;
      end
      @(negedge clk);
      k++;
    end
    d_in = 8'hFF;
    chk("cs_cycles", k, 4);
    chk("wr_pattern", wm, e.wr ? 16'h0006 : 16'h0000);
    chk("rd_pattern", rm, e.wr ? 16'h0000 : 16'h0006);
    chk("ack", ack, e.ack);
    chk("ready", ready, 1);
    chk("bus_released", {cs, rd_n, wr_n, d_oe}, 4'b1110);
    if (!e.wr && e.ack != 0) chk("rdata", rdata, e.din);
    void'(sb.pop_front());
    if (!keep && e.ack != 0) req = 2'b00;
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
  endtask

  task automatic check_init();
    int n;
    push(2'b00, 1'b1, 2'b11, 8'h80, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n = 0;
    while (ppi_reset === 1'b1 && n < 40) begin
      chk("cs_in_reset", {cs, rd_n, wr_n}, 3'b111);
      chk("ready_in_reset", ready, 0);
      @(negedge clk);
      n++;
    end
    chk("rst_pulse_len", n, 4);
    watch_access(0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req = 2'b00; req_wr = 2'b00; req_a = 4'h0; req_wdata = 16'h0000; d_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_ppi_reset", ppi_reset, 1);
    chk("rst_strobes", {cs, rd_n, wr_n}, 3'b111);
    chk("rst_a", a, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ready", ready, 0);

    check_init();

    start_req(0, 1'b1, 2'b00, 8'hA5, 8'h00);
    watch_access(1, 1'b0);
    start_req(1, 1'b0, 2'b01, 8'h00, 8'h3C);
    watch_access(1, 1'b0);
    start_req(1, 1'b1, 2'b10, 8'h77, 8'h00);
    watch_access(1, 1'b0);
    chk("rdata_hold", rdata, 8'h3C);

    // Both requesters held; last grant went to req1, so order is 0,1,0,1
    req_wr = 2'b01; req_a = {2'b10, 2'b00}; req_wdata = {8'h00, 8'h11};
    req = 2'b11;
    push(2'b01, 1'b1, 2'b00, 8'h11, 8'h00);
    push(2'b10, 1'b0, 2'b10, 8'h00, 8'hC3);
    push(2'b01, 1'b1, 2'b00, 8'h11, 8'h00);
    push(2'b10, 1'b0, 2'b10, 8'h00, 8'hC3);
    watch_access(1, 1'b1);
    watch_access(1, 1'b1);
    watch_access(1, 1'b1);
    watch_access(1, 1'b0);
    chk("rdata_after_contention", rdata, 8'hC3);

    // Reset in the middle of a write strobe, with req1 pending across reset
    start_req(0, 1'b1, 2'b01, 8'hC0, 8'h00);
    n = 0;
    while (wr_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_strobe", wr_n, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_bus", {ppi_reset, cs, rd_n, wr_n, d_oe}, 5'b11110);
    chk("async_reset_ack", ack, 0);
    chk("async_reset_ready", ready, 0);
    sb.delete();
    req = 2'b00;
    req_wr[1] = 1'b1; req_a[3:2] = 2'b10; req_wdata[15:8] = 8'h5A;
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_held_ack", ack, 0);
    check_init();
    push(2'b10, 1'b1, 2'b10, 8'h5A, 8'h00);
    watch_access(0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
